mpnc_writeback_buffer: RTL and testbench

- Sits between the L2 cache eviction port and physical memory, on the write side of the memory arbiter.
- Accepts dirty-line evictions into a small FIFO and drains them to physical memory only while the arbiter grants the write path.
- Snoops read addresses so in-flight victims still return correct data.
- Raises wb_pending so the arbiter knows writes are waiting.

---
 rtl/mpnc_writeback_buffer.sv | 244 ++++++++++++++++++++++++
 tb/tb_mpnc_writeback_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpnc_writeback_buffer.sv
// -----------------------------------------------------------------------------
// mpnc_writeback_buffer
//
// Write-back buffer between the L2 eviction port and physical memory. Dirty
// victims are queued in a small FIFO and drained one at a time while the
// memory arbiter grants the write path. Reads are snooped against every
// queued victim so that data still in flight is returned correctly.
//
// Optional feature macro: MPNC_WB_COALESCE_EN
//   defined   : a push whose line address matches a queued entry that is not
//               currently being drained overwrites that entry's data in place.
//   undefined : every push allocates a new entry (default build).
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   wb_write_i      eviction request (level, held until wb_resp_o)
//   wb_address_i    victim byte address
//   wb_wdata_i      victim line data
//   wb_resp_o       one-cycle pulse: eviction accepted
//   rd_address_i    read address to snoop
//   rd_hit_o        rd_address_i matches a valid entry (combinational)
//   rd_rdata_o      data of youngest matching entry, 0 on miss
//   drain_grant_i   arbiter grants memory port to write path
//   wb_pending_o    at least one entry queued (registered)
//   pmem_write_o    write strobe to physical memory
//   pmem_address_o  head entry address with line offset cleared
//   pmem_wdata_o    head entry data
//   pmem_resp_i     physical memory write complete (one-cycle pulse)
// -----------------------------------------------------------------------------
module mpnc_writeback_buffer #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int LINE_OFF = 4,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_write_i,
  input  logic [ADDR_W-1:0] wb_address_i,
  input  logic [LINE_W-1:0] wb_wdata_i,
  output logic              wb_resp_o,
  input  logic [ADDR_W-1:0] rd_address_i,
  output logic              rd_hit_o,
  output logic [LINE_W-1:0] rd_rdata_o,
  input  logic              drain_grant_i,
  output logic              wb_pending_o,
  output logic              pmem_write_o,
  output logic [ADDR_W-1:0] pmem_address_o,
  output logic [LINE_W-1:0] pmem_wdata_o,
  input  logic              pmem_resp_i
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int TAG_W = ADDR_W - LINE_OFF;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // state    | meaning
  // ST_IDLE  | no transfer; start one when entries queued and grant present
  // ST_DRAIN | pmem_write high on head entry, waiting for pmem_resp
  // ST_POP   | transfer done; head retired at the end of this cycle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_POP   = 2'd2;

  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [1:0]        state_q, state_d;

  logic              wb_resp_q;
  logic              wb_pending_q;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic [PTR_W-1:0]  age_idx [DEPTH];
  logic [TAG_W-1:0]  push_tag;
  logic [TAG_W-1:0]  snoop_tag;
  logic              push_req;
  logic              push_alloc;
  logic              push_coal;
  logic              pop_fire;
  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;
  logic              snoop_hit;
  logic [LINE_W-1:0] snoop_data;

  // Line-offset bits never take part in matching or storage.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{wb_address_i[LINE_OFF-1:0], rd_address_i[LINE_OFF-1:0]};

  assign push_tag  = wb_address_i[ADDR_W-1:LINE_OFF];
  assign snoop_tag = rd_address_i[ADDR_W-1:LINE_OFF];

  // age_idx[0] is the head (oldest); higher indices are progressively younger.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_idx[i] = rd_ptr_q + PTR_W'(i);
    end
  end

`ifdef MPNC_WB_COALESCE_EN
  // The head may only be merged into while it has not been launched; once it
  // is on the memory bus its data is committed, so a match allocates instead.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[age_idx[i]] && (tag_q[age_idx[i]] == push_tag) &&
          ((i != 0) || (state_q == ST_IDLE))) begin
        coal_hit = 1'b1;
        coal_idx = age_idx[i];
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  // wb_resp_q blocks the still-held request in the cycle after acceptance.
  assign push_req   = wb_write_i && !wb_resp_q;
  assign push_coal  = push_req && coal_hit;
  assign push_alloc = push_req && !coal_hit && (count_q != FULL_CNT);
  assign pop_fire   = (state_q == ST_POP);

  // Youngest match wins: later (younger) entries overwrite earlier results.
  always_comb begin
    snoop_hit  = 1'b0;
    snoop_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[age_idx[i]] && (tag_q[age_idx[i]] == snoop_tag)) begin
        snoop_hit  = 1'b1;
        snoop_data = data_q[age_idx[i]];
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_fire) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push_alloc) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (push_alloc && !pop_fire) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!push_alloc && pop_fire) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && drain_grant_i) begin
          state_d        = ST_DRAIN;
          pmem_write_d   = 1'b1;
          pmem_address_d = {tag_q[rd_ptr_q], {LINE_OFF{1'b0}}};
          // A merge into the head on the launch edge must reach memory too.
          if (push_coal && (coal_idx == rd_ptr_q)) begin
            pmem_wdata_d = wb_wdata_i;
          end else begin
            pmem_wdata_d = data_q[rd_ptr_q];
          end
        end
      end
      ST_DRAIN: begin
        if (pmem_resp_i) begin
          state_d      = ST_POP;
          pmem_write_d = 1'b0;
        end
      end
      ST_POP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      valid_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      wb_resp_q      <= 1'b0;
      wb_pending_q   <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      wb_resp_q      <= push_alloc || push_coal;
      wb_pending_q   <= (count_d != '0);
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_alloc) begin
      tag_q[wr_ptr_q]  <= push_tag;
      data_q[wr_ptr_q] <= wb_wdata_i;
    end
    if (push_coal) begin
      data_q[coal_idx] <= wb_wdata_i;
    end
  end

  assign wb_resp_o      = wb_resp_q;
  assign wb_pending_o   = wb_pending_q;
  assign rd_hit_o       = snoop_hit;
  assign rd_rdata_o     = snoop_data;
  assign pmem_write_o   = pmem_write_q;
  assign pmem_address_o = pmem_address_q;
  assign pmem_wdata_o   = pmem_wdata_q;

endmodule

// File: tb/tb_mpnc_writeback_buffer.sv
module tb_mpnc_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_write;
  logic [15:0]  wb_address;
  logic [127:0] wb_wdata;
  logic         wb_resp;
  logic [15:0]  rd_address;
  logic         rd_hit;
  logic [127:0] rd_rdata;
  logic         drain_grant;
  logic         wb_pending;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mpnc_writeback_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_write_i    (wb_write),
    .wb_address_i  (wb_address),
    .wb_wdata_i    (wb_wdata),
    .wb_resp_o     (wb_resp),
    .rd_address_i  (rd_address),
    .rd_hit_o      (rd_hit),
    .rd_rdata_o    (rd_rdata),
    .drain_grant_i (drain_grant),
    .wb_pending_o  (wb_pending),
    .pmem_write_o  (pmem_write),
    .pmem_address_o(pmem_address),
    .pmem_wdata_o  (pmem_wdata),
    .pmem_resp_i   (pmem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one line; expects acceptance on the first edge, then lets wb_resp clear.
  task automatic push(input string tag, input logic [15:0] a, input logic [127:0] d);
    wb_write   = 1'b1;
    wb_address = a;
    wb_wdata   = d;
    tick();
    chk({tag, ".resp"}, wb_resp, 1);
    wb_write = 1'b0;
    tick();
    chk({tag, ".resp_pulse"}, wb_resp, 0);
  endtask

  // One full drain: launch, grant dropped mid-transfer, pmem_resp, POP, back to IDLE.
  task automatic drain_one(input string tag, input logic [15:0] a, input logic [127:0] d);
    drain_grant = 1'b1;
    tick();
    chk({tag, ".pwrite"}, pmem_write, 1);
    chk({tag, ".paddr"}, pmem_address, a);
    chk({tag, ".pdata"}, pmem_wdata, d);
    drain_grant = 1'b0;
    tick();
    tick();
    chk({tag, ".pwrite_held"}, pmem_write, 1);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk({tag, ".pop_pwrite"}, pmem_write, 0);
    tick();
  endtask

  logic [127:0] d_a, d_b, d_c, d_d, d_e, d_f, d_g, d_h;
  logic [127:0] f_d [5];

  initial begin
    d_a = {4{32'hA0A0_0001}};
    d_b = {4{32'hB1B1_0002}};
    d_c = {4{32'hC2C2_0003}};
    d_d = {4{32'hD3D3_0004}};
    d_e = {4{32'hE4E4_0005}};
    d_f = {4{32'hF5F5_0006}};
    d_g = {4{32'h1616_0007}};
    d_h = {4{32'h2727_0008}};
    for (int i = 0; i < 5; i++) f_d[i] = {4{32'h5000_0000 + 32'(i)}};

    rst_n = 1'b0; wb_write = 1'b0; wb_address = '0; wb_wdata = '0;
    rd_address = '0; drain_grant = 1'b0; pmem_resp = 1'b0;
    tick(); tick();
    chk("rst.resp", wb_resp, 0);
    chk("rst.pending", wb_pending, 0);
    chk("rst.pwrite", pmem_write, 0);
    chk("rst.paddr", pmem_address, 0);
    chk("rst.pdata", pmem_wdata, 0);
    chk("rst.hit", rd_hit, 0);
    chk("rst.rdata", rd_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Single push, snoop with nonzero offset, no drain without grant.
    wb_write = 1'b1; wb_address = 16'h1230; wb_wdata = d_a;
    tick();
    chk("t1.resp", wb_resp, 1);
    chk("t1.pending", wb_pending, 1);
    wb_write = 1'b0;
    rd_address = 16'h1238;
    #1;
    chk("t1.hit", rd_hit, 1);
    chk("t1.rdata", rd_rdata, d_a);
    rd_address = 16'h1240;
    #1;
    chk("t1.miss_hit", rd_hit, 0);
    chk("t1.miss_rdata", rd_rdata, 0);
    tick();
    chk("t1.resp_pulse", wb_resp, 0);
    tick();
    chk("t1.no_grant", pmem_write, 0);
    drain_one("t1.drain", 16'h1230, d_a);
    chk("t1.pending_low", wb_pending, 0);

    // Single push then grant; pending falls the cycle after POP.
    push("t2.push", 16'h0100, d_b);
    chk("t2.pending", wb_pending, 1);
    rd_address = 16'h0100;
    drain_one("t2.drain", 16'h0100, d_b);
    chk("t2.pending_low", wb_pending, 0);
    chk("t2.hit_gone", rd_hit, 0);

    // Fill, hold a fifth request, accept it one cycle after POP.
    for (int i = 0; i < 4; i++) push("t3.fill", 16'h0300 + 16'(i * 16), f_d[i]);
    wb_write = 1'b1; wb_address = 16'h0340; wb_wdata = f_d[4];
    tick();
    chk("t3.full_resp0", wb_resp, 0);
    tick();
    chk("t3.full_resp1", wb_resp, 0);
    drain_grant = 1'b1;
    tick();
    chk("t3.pwrite", pmem_write, 1);
    chk("t3.paddr", pmem_address, 16'h0300);
    chk("t3.pdata", pmem_wdata, f_d[0]);
    chk("t3.full_resp2", wb_resp, 0);
    drain_grant = 1'b0;
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t3.pop_resp", wb_resp, 0);
    tick();
    chk("t3.popedge_resp", wb_resp, 0);
    tick();
    chk("t3.late_resp", wb_resp, 1);
    wb_write = 1'b0;
    tick();
    chk("t3.resp_pulse", wb_resp, 0);
    rd_address = 16'h0344;
    #1;
    chk("t3.snoop_wrap", rd_rdata, f_d[4]);
    tick(); tick();
    chk("t3.no_regrant", pmem_write, 0);
    for (int i = 1; i < 5; i++) begin
      drain_one("t3.drain", 16'h0300 + 16'(i * 16), f_d[i]);
      tick();
      chk("t3.idle_no_grant", pmem_write, 0);
    end
    chk("t3.pending_low", wb_pending, 0);

    // Duplicate address pushes.
    push("t5.push_c", 16'h0200, d_c);
    push("t5.push_d", 16'h0200, d_d);
    rd_address = 16'h0200;
    #1;
    chk("t5.snoop_hit", rd_hit, 1);
    chk("t5.snoop_young", rd_rdata, d_d);
`ifdef MPNC_WB_COALESCE_EN
    drain_one("t5.drain_d", 16'h0200, d_d);
    chk("t5.pending_low", wb_pending, 0);
`else
    drain_one("t5.drain_c", 16'h0200, d_c);
    chk("t5.pending_mid", wb_pending, 1);
    drain_one("t5.drain_d", 16'h0200, d_d);
    chk("t5.pending_low", wb_pending, 0);
`endif

    // Push accepted on the POP edge: count unchanged, pending stays high.
    push("t6.push_g", 16'h0600, d_g);
    drain_grant = 1'b1;
    tick();
    chk("t6.paddr", pmem_address, 16'h0600);
    drain_grant = 1'b0;
    tick();
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    wb_write = 1'b1; wb_address = 16'h0700; wb_wdata = d_h;
    tick();
    chk("t6.resp", wb_resp, 1);
    chk("t6.pending", wb_pending, 1);
    wb_write = 1'b0;
    tick();
    drain_one("t6.drain_h", 16'h0700, d_h);
    chk("t6.pending_low", wb_pending, 0);

    // Reset in the middle of a drain.
    push("t7.push_e", 16'h0400, d_e);
    push("t7.push_f", 16'h0500, d_f);
    drain_grant = 1'b1;
    tick();
    chk("t7.pwrite", pmem_write, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7.rst_pwrite", pmem_write, 0);
    chk("t7.rst_pending", wb_pending, 0);
    chk("t7.rst_paddr", pmem_address, 0);
    rd_address = 16'h0400;
    #1;
    chk("t7.rst_hit_e", rd_hit, 0);
    rd_address = 16'h0500;
    #1;
    chk("t7.rst_hit_f", rd_hit, 0);
    drain_grant = 1'b0;
    rst_n = 1'b1;
    tick();
    drain_grant = 1'b1;
    tick(); tick();
    chk("t7.post_pwrite", pmem_write, 0);
    chk("t7.post_pending", wb_pending, 0);
    drain_grant = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
